// File: rtl/mash_pkg.sv
// mash_pkg: shared widths and the decoded {int, frac} result type for the MASH decimator
package mash_pkg;
  localparam int DIV_W = 4;
  localparam int FRAC_W = 16;
  localparam int CIC_ORDER = 3;
  typedef struct packed {
    logic [DIV_W-1:0]  i;
    logic [FRAC_W-1:0] f;
  } mash_res_t;
endpackage

// File: rtl/mash_cic_comb.sv
// mash_cic_comb: one registered CIC differentiator stage, y = x - x captured at the previous enable
module mash_cic_comb #(
  parameter int ACC_W = 34
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [ACC_W-1:0] x,
  output logic [ACC_W-1:0] y
);
  logic [ACC_W-1:0] x_d;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      x_d <= '0;
      y <= '0;
    end else if (en) begin
      y <= x - x_d;
      x_d <= x;
    end
endmodule

// File: rtl/mash_decimator.sv
// mash_decimator: sinc^3 CIC decimator recovering the average divide ratio from a MASH 1-1-1 stream.
// Define SETTLE_MASK_EN to hide the first two (unsettled) results behind out_valid=0.
module mash_decimator
  import mash_pkg::*;
#(
  parameter int LOG2_R = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIV_W-1:0]  div_in,
  input  logic              in_valid,
  output logic [DIV_W-1:0]  out_i,
  output logic [FRAC_W-1:0] out_f,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_settled,
  output logic              ovf
);
  localparam int ACC_W = DIV_W + CIC_ORDER * LOG2_R;
  logic [ACC_W-1:0] i1, i2, i3, d0;
  logic [ACC_W-1:0] cs [CIC_ORDER+1];
  logic [LOG2_R-1:0] phase;
  logic [CIC_ORDER:0] stb_d;
  logic [1:0] cnt;
  logic strobe, load, vis;
  logic [ACC_W+FRAC_W-1:0] yw;
  mash_res_t res, y_res;
  assign strobe = in_valid && (&phase);
  assign load = stb_d[CIC_ORDER];
  assign cs[0] = d0;
  // Zero-padding below Y makes the 16-bit fraction slice valid even when Y has fewer fraction bits.
  assign yw = {cs[CIC_ORDER], {FRAC_W{1'b0}}};
  assign y_res = yw[ACC_W+FRAC_W-1 -: DIV_W+FRAC_W];
`ifdef SETTLE_MASK_EN
  assign vis = cnt[1];
`else
  assign vis = 1'b1;
`endif
  assign out_i = res.i;
  assign out_f = res.f;
  assign out_settled = &cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      i1 <= '0;
      i2 <= '0;
      i3 <= '0;
      d0 <= '0;
      phase <= '0;
      stb_d <= '0;
    end else begin
      stb_d <= {stb_d[CIC_ORDER-1:0], strobe};
      if (in_valid) begin
        i1 <= i1 + {{(ACC_W-DIV_W){1'b0}}, div_in};
        i2 <= i2 + i1;
        i3 <= i3 + i2;
        phase <= phase + 1'b1;
      end
      if (strobe) d0 <= i3 + i2;
    end
  for (genvar k = 0; k < CIC_ORDER; k++) begin : g_comb
    mash_cic_comb #(.ACC_W(ACC_W)) u_comb (
      .clk(clk),
      .rst(rst),
      .en (stb_d[k]),
      .x  (cs[k]),
      .y  (cs[k+1])
    );
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      res <= '0;
      cnt <= '0;
      out_valid <= 1'b0;
      ovf <= 1'b0;
    end else begin
      if (load) begin
        res <= y_res;
        cnt <= cnt + {1'b0, ~&cnt};
      end
      if (load && vis) begin
        out_valid <= 1'b1;
        if (out_valid && !out_ready) ovf <= 1'b1;
      end else if (out_valid && out_ready) out_valid <= 1'b0;
    end
endmodule

// File: tb/tb_mash_decimator.sv
// tb_mash_decimator: random and directed checks of mash_decimator against a sinc^3 convolution model
module tb_mash_decimator;
  localparam int R = 4, AW = 10, HL = 3 * R - 2;
`ifdef SETTLE_MASK_EN
  localparam bit MASK = 1'b1;
`else
  localparam bit MASK = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] div_in = '0, out_i;
  logic [15:0] out_f;
  logic in_valid = 1'b0, out_ready = 1'b0, out_valid, out_settled, ovf;
  logic [3:0] b_div = '0, b_i;
  logic [15:0] b_f;
  logic b_in_valid = 1'b0, b_ready = 1'b1, b_valid, b_settled, b_ovf;
  int n_chk = 0, n_fail = 0;
  int h [HL];
  int xs [$];
  longint due_q [$], y_q [$];
  longint cyc = 0, ey = 0;
  bit ev = 0, eo = 0;
  int lc = 0;

  always #5 clk = ~clk;

  mash_decimator #(.LOG2_R(2)) u_dut (
    .clk(clk), .rst(rst), .div_in(div_in), .in_valid(in_valid),
    .out_i(out_i), .out_f(out_f), .out_valid(out_valid), .out_ready(out_ready),
    .out_settled(out_settled), .ovf(ovf)
  );

  mash_decimator #(.LOG2_R(10)) u_big (
    .clk(clk), .rst(rst), .div_in(b_div), .in_valid(b_in_valid),
    .out_i(b_i), .out_f(b_f), .out_valid(b_valid), .out_ready(b_ready),
    .out_settled(b_settled), .ovf(b_ovf)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Decimated output = sinc^3 impulse response convolved with accepted samples, two-sample integrator lag.
  function automatic longint model_y();
    longint s = 0;
    int n = xs.size() - 1;
    for (int j = 0; j < HL; j++)
      if (n - 2 - j >= 0) s += longint'(h[j]) * xs[n-2-j];
    return s % (longint'(1) << AW);
  endfunction

  task automatic step(input bit v, input int d, input bit r);
    bit vis;
    in_valid = v;
    div_in = 4'(d);
    out_ready = r;
    @(posedge clk);
    cyc++;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      void'(due_q.pop_front());
      ey = y_q.pop_front();
      vis = !MASK || lc >= 2;
      if (vis) begin
        if (ev && !r) eo = 1;
        ev = 1;
      end
      if (lc < 3) lc++;
    end else if (ev && r) ev = 0;
    if (v) begin
      xs.push_back(d);
      if (xs.size() % R == 0) begin
        due_q.push_back(cyc + 4);
        y_q.push_back(model_y());
      end
    end
    #1;
    chk("out_valid", out_valid, ev);
    chk("ovf", ovf, eo);
    chk("out_settled", out_settled, lc == 3);
    chk("out_i", out_i, ey >> (AW - 4));
    chk("out_f", out_f, (ey % (longint'(1) << (AW - 4))) << (16 - (AW - 4)));
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_out_i", out_i, 0);
    chk("rst_out_f", out_f, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_settled", out_settled, 0);
    chk("rst_ovf", ovf, 0);
    xs.delete();
    due_q.delete();
    y_q.delete();
    ev = 0;
    eo = 0;
    lc = 0;
    ey = 0;
    @(posedge clk);
    cyc++;
    #1 rst = 1'b0;
  endtask

  initial begin
    int a1 = 0, a2 = 0, a3 = 0, c1, c2, c3, c2d = 0, c3d = 0, c3dd = 0, guard = 0;
    for (int j = 0; j < HL; j++) h[j] = 0;
    for (int a = 0; a < R; a++)
      for (int b = 0; b < R; b++)
        for (int c = 0; c < R; c++) h[a+b+c]++;
    do_reset();
    repeat (40) step(1, 7, 1);
    chk("const7_i", out_i, 7);
    chk("const7_f", out_f, 0);
    chk("const7_settled", out_settled, 1);
    for (int k = 0; k < 40; k++) step(1, 5 + (k % 2), 1);
    chk("alt_i", out_i, 5);
    chk("alt_f", out_f, 16'h8000);
    repeat (12) step(1, $urandom_range(0, 15), 0);
    chk("ovf_set", ovf, 1);
    repeat (8) step(1, 3, 1);
    chk("ovf_sticky", ovf, 1);
    repeat (300) step($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 1));
    for (int k = 0; k < 64; k++) step(k % 2 == 0, 9, 1);
    chk("half_rate_i", out_i, 9);
    chk("half_rate_f", out_f, 0);
    step(1, 9, 1);
    step(1, 9, 1);
    do_reset();
    repeat (8) step(1, 3, 1);
    chk("first_load_valid", out_valid, !MASK);
    chk("first_load_settled", out_settled, 0);
    repeat (4) step(1, 3, 1);
    chk("second_load_settled", out_settled, 0);
    repeat (4) step(1, 3, 1);
    chk("third_load_settled", out_settled, 1);
    chk("third_load_valid", out_valid, 1);
    chk("third_load_i", out_i, 3);
    in_valid = 1'b0;
    while (!(b_valid && b_settled) && guard < 5000) begin
      a1 += 16'h4000;
      c1 = a1 >> 16;
      a1 &= 16'hFFFF;
      a2 += a1;
      c2 = a2 >> 16;
      a2 &= 16'hFFFF;
      a3 += a2;
      c3 = a3 >> 16;
      a3 &= 16'hFFFF;
      b_div = 4'(4 + c1 + c2 - c2d + c3 - 2 * c3d + c3dd);
      c2d = c2;
      c3dd = c3d;
      c3d = c3;
      b_in_valid = 1'b1;
      @(posedge clk);
      #1;
      guard++;
    end
    chk("big_timeout", guard < 5000, 1);
    chk("big_i", b_i, 4);
    chk("big_f_window", b_f >= 16'h3FFF && b_f <= 16'h4001, 1);
    chk("big_ovf", b_ovf, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
